pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter stage of the 64-bit RISC-V single-cycle CPU.
- Consumes the branch offset from the shift-left-by-1 stage (immediate << 1) and forms the branch target.
- Selects and registers the next PC, and drives the instruction-memory fetch request.
- Traps on misaligned control-flow targets.

Parameters:
- XLEN, 64, datapath and PC width.
- RESET_PC, 64'h0000_0000_0000_0000, PC value loaded by reset.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- shifted_offset  in  XLEN  branch offset already shifted left by 1, sign-extended.
- branch_taken  in  1  resolved conditional branch / JAL redirect.
- jalr_sel  in  1  JALR redirect request.
- jalr_target  in  XLEN  rs1+imm for JALR, unmasked.
- stall  in  1  hold PC this cycle.
- imem_ready  in  1  instruction memory accepts the current fetch.
- pc  out  XLEN  current fetch address (registered).
- pc_plus4  out  XLEN  pc+4, combinational, wraps mod 2^64.
- branch_target  out  XLEN  pc+shifted_offset, combinational, wraps mod 2^64.
- imem_req  out  1  fetch request valid.
- trap_misaligned  out  1  sticky misaligned-target flag.
- trap_pc  out  XLEN  offending target address.
- fetch_count  out  CNT_W  number of accepted fetches, wraps.

Behaviour:
- Reset is synchronous and active-high. It dominates every other input and is valid mid-operation.
- Reset values: pc=RESET_PC, imem_req=0, trap_misaligned=0, trap_pc=0, fetch_count=0, state=S_BOOT.
- FSM has three states:
  - S_BOOT: one cycle with imem_req=0. Unconditional transition to S_FETCH.
  - S_FETCH: imem_req=1. The PC advances only on accept = imem_ready & ~stall; otherwise pc holds.
  - S_TRAP: imem_req=0, pc frozen, trap_misaligned=1. Exits only via reset.
- Next-PC priority on accept:
  1. jalr_sel: target = {jalr_target[XLEN-1:1],1'b0}.
  2. branch_taken: target = branch_target.
  3. Otherwise pc_plus4.
- Alignment (IALIGN=32): a selected redirect target with target[1]!=0 is misaligned.
  - On accept: pc is NOT updated, trap_pc<=target, trap_misaligned<=1, state<=S_TRAP. fetch_count still increments.
  - Sequential pc_plus4 never traps.
- fetch_count increments by 1 on every accept and wraps 2^CNT_W-1 -> 0.
- Stall with a redirect pending: stall wins. The redirect inputs must be held by the upstream stage until accept.
- Wrap-around: pc=64'hFFFF_FFFF_FFFF_FFFC sequential -> 0. Branch target arithmetic is modulo 2^64 with no overflow flag.
- Latency: a redirect is visible on pc in the cycle after accept. branch_target and pc_plus4 follow pc combinationally with 0 latency.
- All outputs are glitch-free registered values, except pc_plus4 and branch_target.

Decomposition:
- Package pc_fetch_pkg holds:
  - XLEN, INSTR_BYTES=4, and the default RESET_PC.
  - The state enum with 2-bit encoding: S_BOOT=0, S_FETCH=1, S_TRAP=2.
- One sub-module, pc_target_calc (combinational). It computes:
  - pc_plus4 and branch_target.
  - The masked jalr target.
  - The priority-selected next_pc and its misaligned flag.
- The top level keeps the FSM, pc register, trap registers and counter.

Test Plan:
1. Assert reset 2 cycles then release -> pc=0, imem_req=0 for 1 cycle, then 1. With imem_ready=1 and no redirect, pc = 0,4,8,0xC on successive cycles; fetch_count=3 at pc=0xC.
2. Branch forward and back:
   - pc=0x8, shifted_offset=0x10, branch_taken=1 -> branch_target=0x18; next pc=0x18.
   - Then shifted_offset=64'hFFFF_FFFF_FFFF_FFF8 -> next pc=0x10.
3. Stall and memory-not-ready:
   - pc=0x10, branch_taken=1, offset=0x40, stall=1 for 3 cycles -> pc holds 0x10, fetch_count unchanged.
   - stall=0 with imem_ready=0 -> still 0x10.
   - imem_ready=1 -> pc=0x50.
4. JALR priority: jalr_sel=1, jalr_target=0x1001, branch_taken=1, offset=0x8 -> next pc=0x1000, branch ignored.
5. Misaligned trap:
   - pc=0x20, offset=0x2, branch_taken=1 -> pc stays 0x20, trap_misaligned=1, trap_pc=0x22, imem_req=0.
   - Flag stays set across 5 further cycles.
   - Synchronous reset clears it, and pc returns to RESET_PC.
6. Wrap: force pc to 64'hFFFF_FFFF_FFFF_FFFC via RESET_PC override, accept sequentially -> pc=0; fetch_count from 32'hFFFF_FFFF increments to 0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared widths, default reset pc and fetch fsm states
package pc_fetch_pkg;
  localparam int XLEN = 64;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_FETCH = 2'd1, S_TRAP = 2'd2} state_t;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: sequential/branch/jalr targets, priority next-pc select and misalignment flag
module pc_target_calc #(
  parameter int XLEN = pc_fetch_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] shifted_offset,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            branch_taken,
  input  logic            jalr_sel,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);
  logic [XLEN-1:0] jalr_masked;
  assign pc_plus4 = pc + XLEN'(pc_fetch_pkg::INSTR_BYTES);
  assign branch_target = pc + shifted_offset;
  assign jalr_masked = {jalr_target[XLEN-1:1], 1'b0};
  assign next_pc = jalr_sel ? jalr_masked : branch_taken ? branch_target : pc_plus4;
  assign misaligned = (jalr_sel | branch_taken) & next_pc[1];
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter register, fetch request fsm, misaligned-target trap and fetch counter
module pc_fetch_unit #(
  parameter int                  XLEN     = pc_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]     RESET_PC = pc_fetch_pkg::DEFAULT_RESET_PC,
  parameter int                  CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  shifted_offset,
  input  logic             branch_taken,
  input  logic             jalr_sel,
  input  logic [XLEN-1:0]  jalr_target,
  input  logic             stall,
  input  logic             imem_ready,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [XLEN-1:0]  branch_target,
  output logic             imem_req,
  output logic             trap_misaligned,
  output logic [XLEN-1:0]  trap_pc,
  output logic [CNT_W-1:0] fetch_count
);
  import pc_fetch_pkg::*;
  state_t state, next_state;
  logic [XLEN-1:0] next_pc;
  logic misaligned, accept;
  pc_target_calc #(.XLEN(XLEN)) u_calc (
    .pc(pc),
    .shifted_offset(shifted_offset),
    .jalr_target(jalr_target),
    .branch_taken(branch_taken),
    .jalr_sel(jalr_sel),
    .pc_plus4(pc_plus4),
    .branch_target(branch_target),
    .next_pc(next_pc),
    .misaligned(misaligned)
  );
  assign accept = (state == S_FETCH) & imem_ready & ~stall;
  always_comb next_state = state == S_BOOT ? S_FETCH : (accept & misaligned) ? S_TRAP : state;
  always_ff @(posedge clk)
    state <= reset ? S_BOOT : next_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      imem_req <= 1'b0;
      trap_misaligned <= 1'b0;
      trap_pc <= '0;
      fetch_count <= '0;
    end else begin
      imem_req <= next_state == S_FETCH;
      if (accept) begin
        fetch_count <= fetch_count + 1'b1;
        if (misaligned) begin
          trap_pc <= next_pc;
          trap_misaligned <= 1'b1;
        end else begin
          pc <= next_pc;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checking of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, branch_taken, jalr_sel, stall, imem_ready;
  logic [63:0] shifted_offset, jalr_target;
  logic [63:0] pc, pc_plus4, branch_target, trap_pc;
  logic imem_req, trap_misaligned;
  logic [31:0] fetch_count;
  logic w_reset;
  logic [63:0] w_pc, w_pp4, w_bt, w_tpc;
  logic w_req, w_trap;
  logic [3:0] w_cnt;
  int checks = 0, errors = 0;
  logic m_live = 1'b0, m_boot = 1'b1, m_trap = 1'b0;
  logic [63:0] m_pc = '0, m_tpc = '0, m_tgt;
  logic [31:0] m_cnt = '0;
  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .shifted_offset(shifted_offset), .branch_taken(branch_taken),
    .jalr_sel(jalr_sel), .jalr_target(jalr_target), .stall(stall), .imem_ready(imem_ready),
    .pc(pc), .pc_plus4(pc_plus4), .branch_target(branch_target), .imem_req(imem_req),
    .trap_misaligned(trap_misaligned), .trap_pc(trap_pc), .fetch_count(fetch_count)
  );
  pc_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .CNT_W(4)) dut_w (
    .clk(clk), .reset(w_reset), .shifted_offset(64'd0), .branch_taken(1'b0),
    .jalr_sel(1'b0), .jalr_target(64'd0), .stall(1'b0), .imem_ready(1'b1),
    .pc(w_pc), .pc_plus4(w_pp4), .branch_target(w_bt), .imem_req(w_req),
    .trap_misaligned(w_trap), .trap_pc(w_tpc), .fetch_count(w_cnt)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_live = 1'b1;
      m_boot = 1'b1;
      m_trap = 1'b0;
      m_pc = 64'd0;
      m_tpc = 64'd0;
      m_cnt = 32'd0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_trap && imem_ready && !stall) begin
      m_cnt = m_cnt + 32'd1;
      m_tgt = jalr_sel ? (jalr_target & ~64'd1) : branch_taken ? m_pc + shifted_offset : m_pc + 64'd4;
      if ((jalr_sel || branch_taken) && m_tgt[1]) begin
        m_trap = 1'b1;
        m_tpc = m_tgt;
      end else begin
        m_pc = m_tgt;
      end
    end
  end
  always @(negedge clk) begin
    if (m_live) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 64'd4);
      chk("branch_target", branch_target, m_pc + shifted_offset);
      chk("imem_req", 64'(imem_req), 64'(!m_boot && !m_trap));
      chk("trap_misaligned", 64'(trap_misaligned), 64'(m_trap));
      chk("trap_pc", trap_pc, m_tpc);
      chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic rand_inputs(input logic allow_reset);
    reset = allow_reset && ($urandom_range(63) == 0);
    stall = $urandom_range(3) == 0;
    imem_ready = $urandom_range(3) != 0;
    branch_taken = $urandom_range(2) == 0;
    jalr_sel = $urandom_range(5) == 0;
    shifted_offset = ({$urandom, $urandom} & ~64'd3) | ($urandom_range(9) == 0 ? 64'd2 : 64'd0);
    jalr_target = ({$urandom, $urandom} & ~64'd3) | ($urandom_range(9) == 0 ? 64'd2 : 64'd0) | 64'($urandom_range(1));
  endtask
  initial begin
    w_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 w_reset = 1'b0;
    @(negedge clk);
    chk("wrap boot pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap pc_plus4", w_pp4, 64'd0);
    chk("wrap boot req", 64'(w_req), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("wrap fetch req", 64'(w_req), 64'd1);
    chk("wrap cnt0", 64'(w_cnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("wrap pc to zero", w_pc, 64'd0);
    chk("wrap cnt1", 64'(w_cnt), 64'd1);
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("wrap cnt max", 64'(w_cnt), 64'd15);
    chk("wrap pc 0x38", w_pc, 64'h38);
    @(posedge clk);
    @(negedge clk);
    chk("wrap cnt to zero", 64'(w_cnt), 64'd0);
    chk("wrap pc 0x3c", w_pc, 64'h3C);
    chk("wrap no trap", {w_bt ^ w_pc, w_tpc} == 128'd0 && !w_trap ? 64'd1 : 64'd0, 64'd1);
  end
  initial begin
    reset = 1'b1;
    stall = 1'b0;
    imem_ready = 1'b1;
    branch_taken = 1'b0;
    jalr_sel = 1'b0;
    shifted_offset = '0;
    jalr_target = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t1 boot pc", pc, 64'd0);
    chk("t1 boot req", 64'(imem_req), 64'd0);
    step;
    @(negedge clk);
    chk("t1 fetch req", 64'(imem_req), 64'd1);
    chk("t1 pc0", pc, 64'd0);
    step;
    @(negedge clk);
    chk("t1 pc4", pc, 64'd4);
    step;
    @(negedge clk);
    chk("t1 pc8", pc, 64'd8);
    step;
    branch_taken = 1'b1;
    shifted_offset = 64'h10;
    @(negedge clk);
    chk("t1 pcC", pc, 64'hC);
    chk("t1 count3", 64'(fetch_count), 64'd3);
    chk("t2 fwd target", branch_target, 64'h1C);
    step;
    shifted_offset = 64'hFFFF_FFFF_FFFF_FFF8;
    @(negedge clk);
    chk("t2 fwd pc", pc, 64'h1C);
    chk("t2 back target", branch_target, 64'h14);
    step;
    shifted_offset = 64'h40;
    stall = 1'b1;
    @(negedge clk);
    chk("t2 back pc", pc, 64'h14);
    chk("t2 count5", 64'(fetch_count), 64'd5);
    repeat (3) begin
      step;
      @(negedge clk);
      chk("t3 stall pc", pc, 64'h14);
      chk("t3 stall count", 64'(fetch_count), 64'd5);
    end
    stall = 1'b0;
    imem_ready = 1'b0;
    step;
    @(negedge clk);
    chk("t3 not ready pc", pc, 64'h14);
    imem_ready = 1'b1;
    step;
    jalr_sel = 1'b1;
    jalr_target = 64'h1001;
    shifted_offset = 64'h8;
    @(negedge clk);
    chk("t3 accept pc", pc, 64'h54);
    chk("t3 count6", 64'(fetch_count), 64'd6);
    step;
    jalr_sel = 1'b0;
    shifted_offset = 64'h2;
    @(negedge clk);
    chk("t4 jalr pc", pc, 64'h1000);
    step;
    @(negedge clk);
    chk("t5 trap pc held", pc, 64'h1000);
    chk("t5 trap flag", 64'(trap_misaligned), 64'd1);
    chk("t5 trap_pc", trap_pc, 64'h1002);
    chk("t5 trap req", 64'(imem_req), 64'd0);
    chk("t5 count8", 64'(fetch_count), 64'd8);
    repeat (5) begin
      step;
      rand_inputs(1'b0);
      @(negedge clk);
      chk("t5 sticky flag", 64'(trap_misaligned), 64'd1);
      chk("t5 sticky pc", pc, 64'h1000);
    end
    reset = 1'b1;
    step;
    reset = 1'b0;
    @(negedge clk);
    chk("t5 reset pc", pc, 64'd0);
    chk("t5 reset flag", 64'(trap_misaligned), 64'd0);
    chk("t5 reset count", 64'(fetch_count), 64'd0);
    repeat (3000) begin
      step;
      rand_inputs(1'b1);
    end
    repeat (2) step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
